// File: rtl/aibcr3_rxmode_seq_if.sv
// Receive-mode sequencer bus: mode request handshake plus driven rx datapath controls.
interface aibcr3_rxmode_seq_if;
  logic       mode_req;
  logic [2:0] mode_new;
  logic       force_dis;
  logic [2:0] irxen;
  logic       rx_dp_rstb;
  logic       busy;
  logic       mode_ack;
  logic       mode_err;

  // Requester side
  modport master (
    output mode_req, mode_new, force_dis,
    input  irxen, rx_dp_rstb, busy, mode_ack, mode_err
  );

  // Sequencer side
  modport slave (
    input  mode_req, mode_new, force_dis,
    output irxen, rx_dp_rstb, busy, mode_ack, mode_err
  );
endinterface

// File: rtl/aibcr3_rxmode_seq.sv
// Receive-mode switch sequencer: drains the rx datapath under reset, switches
// irxen, lets it settle, then releases reset and acknowledges the request.
module aibcr3_rxmode_seq #(
  parameter int unsigned DRAIN_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 8
) (
  input logic                    iclkin_dist,
  input logic                    irstb,
  aibcr3_rxmode_seq_if.slave     bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned MODE_W = 3;
  localparam logic [CNT_W-1:0]  DRAIN_LOAD  = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [MODE_W-1:0] MODE_DIS    = 3'b010;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_SWITCH,
    ST_SETTLE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MODE_W-1:0]   tgt_q, tgt_d;
  logic [MODE_W-1:0]   irxen_q, irxen_d;
  logic                seq_req_q, seq_req_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                rstb_q, rstb_d;
  logic                force_go;

  // Legal irxen encodings are 000, 001, 010, 011 and 100
  function automatic logic is_legal(input logic [MODE_W-1:0] m);
    logic ok;
    case (m)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b100: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // force_dis is a no-op only when already idle in the disable mode
  assign force_go = bus.force_dis && !((state_q == ST_ACTIVE) && (irxen_q == MODE_DIS));

  // Next-state, counter, target and pulse decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    irxen_d   = irxen_q;
    seq_req_d = seq_req_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    if (force_go) begin
      // Abort whatever is running and restart the drain toward disable
      state_d   = ST_DRAIN;
      cnt_d     = DRAIN_LOAD;
      tgt_d     = MODE_DIS;
      seq_req_d = 1'b0;
      err_d     = bus.mode_req || ((state_q != ST_ACTIVE) && seq_req_q);
    end else if (bus.force_dis) begin
      err_d = bus.mode_req;
    end else begin
      case (state_q)
        ST_ACTIVE: begin
          if (bus.mode_req) begin
            if (!is_legal(bus.mode_new)) begin
              err_d = 1'b1;
            end else if (bus.mode_new == irxen_q) begin
              ack_d = 1'b1;
            end else begin
              state_d   = ST_DRAIN;
              cnt_d     = DRAIN_LOAD;
              tgt_d     = bus.mode_new;
              seq_req_d = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          err_d = bus.mode_req;
          if (cnt_q == '0) begin
            state_d = ST_SWITCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_SWITCH: begin
          err_d   = bus.mode_req;
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
          irxen_d = tgt_q;
        end
        ST_SETTLE: begin
          err_d = bus.mode_req;
          if (cnt_q == '0) begin
            state_d   = ST_ACTIVE;
            cnt_d     = '0;
            ack_d     = seq_req_q;
            // Completion ack takes the slot; a request dropped in the same cycle gets no err
            err_d     = bus.mode_req && !seq_req_q;
            seq_req_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_ACTIVE);
    rstb_d = (state_d == ST_ACTIVE) && (irxen_d != MODE_DIS);
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge iclkin_dist) begin
    if (!irstb) begin
      state_q   <= ST_ACTIVE;
      cnt_q     <= '0;
      tgt_q     <= MODE_DIS;
      irxen_q   <= MODE_DIS;
      seq_req_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rstb_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      irxen_q   <= irxen_d;
      seq_req_q <= seq_req_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rstb_q    <= rstb_d;
    end
  end

  assign bus.irxen      = irxen_q;
  assign bus.rx_dp_rstb = rstb_q;
  assign bus.busy       = busy_q;
  assign bus.mode_ack   = ack_q;
  assign bus.mode_err   = err_q;

endmodule

// File: tb/tb_aibcr3_rxmode_seq.sv
// Bench for aibcr3_rxmode_seq: default-timing and minimum-timing instances
// driven with identical stimulus and checked against a cycle-arithmetic model.
module tb_aibcr3_rxmode_seq;

  localparam int D0 = 4;
  localparam int S0 = 8;
  localparam int D1 = 1;
  localparam int S1 = 1;

  logic clk;
  logic irstb;
  int   checks;
  int   errors;
  int   cyc;

  aibcr3_rxmode_seq_if bus0 ();
  aibcr3_rxmode_seq_if bus1 ();

  aibcr3_rxmode_seq #(.DRAIN_CYC(D0), .SETTLE_CYC(S0)) dut0 (
    .iclkin_dist (clk),
    .irstb       (irstb),
    .bus         (bus0.slave)
  );

  aibcr3_rxmode_seq #(.DRAIN_CYC(D1), .SETTLE_CYC(S1)) dut1 (
    .iclkin_dist (clk),
    .irstb       (irstb),
    .bus         (bus1.slave)
  );

  logic [2:0] o_irxen [2];
  logic       o_rstb  [2];
  logic       o_busy  [2];
  logic       o_ack   [2];
  logic       o_err   [2];

  assign o_irxen[0] = bus0.irxen;      assign o_irxen[1] = bus1.irxen;
  assign o_rstb[0]  = bus0.rx_dp_rstb; assign o_rstb[1]  = bus1.rx_dp_rstb;
  assign o_busy[0]  = bus0.busy;       assign o_busy[1]  = bus1.busy;
  assign o_ack[0]   = bus0.mode_ack;   assign o_ack[1]   = bus1.mode_ack;
  assign o_err[0]   = bus0.mode_err;   assign o_err[1]   = bus1.mode_err;

  // Model: a sequence started from inputs of cycle t0 switches irxen at t0+D+2
  // and returns to ACTIVE at t0+D+S+2.
  int         md [2] = '{D0, D1};
  int         ms [2] = '{S0, S1};
  bit         m_inseq  [2];
  bit         m_seqreq [2];
  int         m_t0     [2];
  logic [2:0] m_tgt    [2];
  logic [2:0] m_irxen  [2];
  bit         m_ack    [2];
  bit         m_err    [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit m_rstb(input int k);
    return !m_inseq[k] && (m_irxen[k] != 3'b010);
  endfunction

  task automatic model_step(input int k, input bit req, input logic [2:0] nw,
                            input bit frc, input bit rst);
    int x;
    x = cyc + 1;
    m_ack[k] = 1'b0;
    m_err[k] = 1'b0;
    if (!rst) begin
      m_inseq[k]  = 1'b0;
      m_seqreq[k] = 1'b0;
      m_irxen[k]  = 3'b010;
      m_tgt[k]    = 3'b010;
    end else if (frc && (m_inseq[k] || m_irxen[k] != 3'b010)) begin
      m_err[k]    = req || (m_inseq[k] && m_seqreq[k]);
      m_inseq[k]  = 1'b1;
      m_seqreq[k] = 1'b0;
      m_tgt[k]    = 3'b010;
      m_t0[k]     = cyc;
    end else if (frc) begin
      m_err[k] = req;
    end else if (m_inseq[k]) begin
      m_err[k] = req;
      if (x == m_t0[k] + md[k] + 2) m_irxen[k] = m_tgt[k];
      if (x == m_t0[k] + md[k] + ms[k] + 2) begin
        m_inseq[k] = 1'b0;
        if (m_seqreq[k]) begin
          m_ack[k] = 1'b1;
          m_err[k] = 1'b0;
        end
        m_seqreq[k] = 1'b0;
      end
    end else if (req) begin
      if (nw > 3'd4) m_err[k] = 1'b1;
      else if (nw == m_irxen[k]) m_ack[k] = 1'b1;
      else begin
        m_inseq[k]  = 1'b1;
        m_seqreq[k] = 1'b1;
        m_tgt[k]    = nw;
        m_t0[k]     = cyc;
      end
    end
  endtask

  // Drive one cycle of inputs to both instances, advance model, sample after edge
  task automatic tick(input bit req, input logic [2:0] nw, input bit frc, input bit rst);
    bus0.mode_req = req; bus0.mode_new = nw; bus0.force_dis = frc;
    bus1.mode_req = req; bus1.mode_new = nw; bus1.force_dis = frc;
    irstb = rst;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, req, nw, frc, rst);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_irxen[k] !== 3'b010 || o_rstb[k] !== 1'b0 || o_busy[k] !== 1'b0 ||
          o_ack[k] !== 1'b0 || o_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: irxen=%b rstb=%b busy=%b ack=%b err=%b, want 010 0 0 0 0",
                 k, o_irxen[k], o_rstb[k], o_busy[k], o_ack[k], o_err[k]);
      end
    end
  endtask

  // First request right after reset release, default timing
  task automatic test_basic_switch();
    for (int i = 0; i < 14; i++) begin
      int x;
      tick(i == 0, 3'b001, 1'b0, 1'b1);
      x = i + 1;
      checks++;
      if (o_busy[0] !== (x <= 13) || o_ack[0] !== (x == 14) || o_err[0] !== 1'b0 ||
          o_irxen[0] !== ((x >= 6) ? 3'b001 : 3'b010) || o_rstb[0] !== (x == 14)) begin
        errors++;
        $display("FAIL basic_switch N+%0d: busy=%b ack=%b err=%b irxen=%b rstb=%b, want %b %b 0 %b %b",
                 x, o_busy[0], o_ack[0], o_err[0], o_irxen[0], o_rstb[0],
                 x <= 13, x == 14, (x >= 6) ? 3'b001 : 3'b010, x == 14);
      end
    end
  endtask

  task automatic test_illegal();
    for (int v = 5; v < 8; v++) begin
      tick(1'b1, 3'(v), 1'b0, 1'b1);
      checks++;
      if (o_err[0] !== 1'b1 || o_ack[0] !== 1'b0 || o_irxen[0] !== 3'b001 ||
          o_rstb[0] !== 1'b1 || o_busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL illegal %b: err=%b ack=%b irxen=%b rstb=%b busy=%b, want 1 0 001 1 0",
                 3'(v), o_err[0], o_ack[0], o_irxen[0], o_rstb[0], o_busy[0]);
      end
    end
    tick(1'b0, 3'b000, 1'b0, 1'b1);
    checks++;
    if (o_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse_width: err=%b, want 0", o_err[0]);
    end
  endtask

  // 001 -> 011 with a second request 100 dropped while busy
  task automatic test_busy_drop();
    for (int i = 0; i < 14; i++) begin
      int x;
      tick(i == 0 || i == 3, (i == 3) ? 3'b100 : 3'b011, 1'b0, 1'b1);
      x = i + 1;
      checks++;
      if (o_err[0] !== (x == 4) || o_ack[0] !== (x == 14)) begin
        errors++;
        $display("FAIL busy_drop N+%0d: err=%b ack=%b, want %b %b",
                 x, o_err[0], o_ack[0], x == 4, x == 14);
      end
    end
    checks++;
    if (o_irxen[0] !== 3'b011) begin
      errors++;
      $display("FAIL busy_drop_final: irxen=%b, want 011", o_irxen[0]);
    end
  endtask

  task automatic test_same_mode();
    for (int i = 0; i < 4; i++) begin
      tick(i == 0, 3'b011, 1'b0, 1'b1);
      checks++;
      if (o_ack[0] !== (i == 0) || o_busy[0] !== 1'b0 || o_err[0] !== 1'b0 ||
          o_irxen[0] !== 3'b011) begin
        errors++;
        $display("FAIL same_mode +%0d: ack=%b busy=%b err=%b irxen=%b, want %b 0 0 011",
                 i + 1, o_ack[0], o_busy[0], o_err[0], o_irxen[0], i == 0);
      end
    end
  endtask

  // 000 -> 100 aborted by force_dis in SETTLE (cycle M = N+8)
  task automatic test_force_abort();
    for (int i = 0; i < 14; i++) tick(i == 0, 3'b000, 1'b0, 1'b1);
    checks++;
    if (o_irxen[0] !== 3'b000) begin
      errors++;
      $display("FAIL force_setup: irxen=%b, want 000", o_irxen[0]);
    end
    for (int i = 0; i < 25; i++) begin
      int x;
      logic [2:0] ex;
      tick(i == 0, 3'b100, i == 8, 1'b1);
      x = i + 1;
      ex = (x < 6) ? 3'b000 : ((x <= 13) ? 3'b100 : 3'b010);
      checks++;
      if (o_err[0] !== (x == 9) || o_ack[0] !== 1'b0 || o_rstb[0] !== 1'b0 ||
          o_irxen[0] !== ex || o_busy[0] !== (x <= 21)) begin
        errors++;
        $display("FAIL force_abort N+%0d: err=%b ack=%b rstb=%b irxen=%b busy=%b, want %b 0 0 %b %b",
                 x, o_err[0], o_ack[0], o_rstb[0], o_irxen[0], o_busy[0], x == 9, ex, x <= 21);
      end
    end
    tick(1'b0, 3'b000, 1'b1, 1'b1);
    checks++;
    if (o_busy[0] !== 1'b0 || o_ack[0] !== 1'b0 || o_err[0] !== 1'b0 || o_irxen[0] !== 3'b010) begin
      errors++;
      $display("FAIL force_idle_dis: busy=%b ack=%b err=%b irxen=%b, want 0 0 0 010",
               o_busy[0], o_ack[0], o_err[0], o_irxen[0]);
    end
    tick(1'b1, 3'b001, 1'b1, 1'b1);
    checks++;
    if (o_err[0] !== 1'b1 || o_busy[0] !== 1'b0 || o_ack[0] !== 1'b0 || o_irxen[0] !== 3'b010) begin
      errors++;
      $display("FAIL force_vs_req: err=%b busy=%b ack=%b irxen=%b, want 1 0 0 010",
               o_err[0], o_busy[0], o_ack[0], o_irxen[0]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) tick(i == 0, 3'b001, 1'b0, 1'b1);
    tick(1'b0, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_irxen[k] !== 3'b010 || o_busy[k] !== 1'b0 || o_ack[k] !== 1'b0 ||
          o_err[k] !== 1'b0 || o_rstb[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid dut%0d: irxen=%b busy=%b ack=%b err=%b rstb=%b, want 010 0 0 0 0",
                 k, o_irxen[k], o_busy[k], o_ack[k], o_err[k], o_rstb[k]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 3'b000, 1'b0, 1'b1);
      checks++;
      if (o_ack[0] !== 1'b0 || o_err[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet +%0d: ack=%b err=%b busy=%b, want 0 0 0",
                 i + 1, o_ack[0], o_err[0], o_busy[0]);
      end
    end
  endtask

  // Minimum timing instance completes at N+4
  task automatic test_fast();
    for (int i = 0; i < 14; i++) begin
      int x;
      tick(i == 0, 3'b011, 1'b0, 1'b1);
      x = i + 1;
      checks++;
      if (o_ack[1] !== (x == 4) || o_busy[1] !== (x <= 3) ||
          o_irxen[1] !== ((x >= 3) ? 3'b011 : 3'b010) || o_rstb[1] !== (x >= 4)) begin
        errors++;
        $display("FAIL fast N+%0d: ack=%b busy=%b irxen=%b rstb=%b, want %b %b %b %b",
                 x, o_ack[1], o_busy[1], o_irxen[1], o_rstb[1],
                 x == 4, x <= 3, (x >= 3) ? 3'b011 : 3'b010, x >= 4);
      end
    end
    checks++;
    if (o_ack[0] !== 1'b1) begin
      errors++;
      $display("FAIL fast_default_ack: ack=%b, want 1", o_ack[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      bit rst, frc, req;
      logic [2:0] nw;
      rst = ($urandom_range(0, 299) != 0);
      frc = ($urandom_range(0, 59) == 0);
      req = ($urandom_range(0, 4) == 0);
      nw  = 3'($urandom_range(0, 7));
      tick(req, nw, frc, rst);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_irxen[k] !== m_irxen[k] || o_busy[k] !== m_inseq[k] || o_rstb[k] !== m_rstb(k) ||
            o_ack[k] !== m_ack[k] || o_err[k] !== m_err[k]) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d: irxen=%b busy=%b rstb=%b ack=%b err=%b, want %b %b %b %b %b",
                   k, cyc, o_irxen[k], o_busy[k], o_rstb[k], o_ack[k], o_err[k],
                   m_irxen[k], m_inseq[k], m_rstb(k), m_ack[k], m_err[k]);
        end
        checks++;
        if (o_ack[k] === 1'b1 && o_err[k] === 1'b1) begin
          errors++;
          $display("FAIL ack_err_excl dut%0d cyc %0d: ack=%b err=%b, want not both",
                   k, cyc, o_ack[k], o_err[k]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    irstb  = 1'b0;
    bus0.mode_req = 1'b0; bus0.mode_new = 3'b000; bus0.force_dis = 1'b0;
    bus1.mode_req = 1'b0; bus1.mode_new = 3'b000; bus1.force_dis = 1'b0;
    test_reset();
    test_basic_switch();
    test_illegal();
    test_busy_drop();
    test_same_mode();
    test_force_abort();
    test_reset_mid();
    test_fast();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aibcr3_rxmode_seq.md
AIBCR3_RXMODE_SEQ -- requirements
Module: aibcr3_rxmode_seq

Interface
REQ-001 Parameter DRAIN_CYC, default 4, number of cycles the datapath is held in reset before the mode switches; legal range 1..15.
REQ-002 Parameter SETTLE_CYC, default 8, number of cycles after the mode switch before the datapath reset releases; legal range 1..15.
REQ-003 iclkin_dist  input  1  single clock; all state changes on its rising edge.
REQ-004 irstb  input  1  reset; synchronous and active-low.
REQ-005 mode_req  input  1  single-cycle request to change the receive mode.
REQ-006 mode_new  input  3  requested irxen encoding, sampled when mode_req=1.
REQ-007 force_dis  input  1  synchronous disable request; highest priority after reset.
REQ-008 irxen  output  3  registered receive-mode enable driven to the rx datapath.
REQ-009 rx_dp_rstb  output  1  registered active-low datapath reset driven to the rx datapath.
REQ-010 busy  output  1  high whenever the state is not ACTIVE.
REQ-011 mode_ack  output  1  one-cycle pulse when a request completes.
REQ-012 mode_err  output  1  one-cycle pulse when a request is rejected or aborted.

Function
REQ-013 The legal irxen encodings SHALL be 000 (async), 001 (sync data), 011 (clock), 100 (SDR/PD) and 010 (disable); 101, 110 and 111 SHALL be illegal.
REQ-014 The FSM states SHALL be ACTIVE, DRAIN, SWITCH and SETTLE; an internal 3-bit target register holds the pending mode.
REQ-015 ACTIVE, mode_req=1, mode_new legal and not equal to irxen: the block SHALL latch the target and enter DRAIN on the next cycle.
REQ-016 ACTIVE, mode_req=1, mode_new equal to irxen: the block SHALL remain in ACTIVE and pulse mode_ack on the next cycle.
REQ-017 ACTIVE, mode_req=1, mode_new illegal: the block SHALL remain in ACTIVE, leave irxen unchanged and pulse mode_err on the next cycle.
REQ-018 mode_req=1 while busy=1 SHALL be dropped and SHALL pulse mode_err on the next cycle; the operation in progress SHALL continue unaffected.
REQ-019 rx_dp_rstb SHALL be 0 during DRAIN, SWITCH and SETTLE.
REQ-020 DRAIN SHALL last exactly DRAIN_CYC cycles and then go to SWITCH.
REQ-021 SWITCH SHALL last one cycle, and irxen SHALL take the target value in the first SETTLE cycle.
REQ-022 SETTLE SHALL last exactly SETTLE_CYC cycles and then go to ACTIVE.
REQ-023 In the first ACTIVE cycle after SETTLE, mode_ack SHALL be 1 for one cycle, busy SHALL be 0, and rx_dp_rstb SHALL be 1 unless irxen=010.
REQ-024 Latency with a request sampled in ACTIVE at cycle N:
- DRAIN during N+1 .. N+DRAIN_CYC
- irxen changes at N+DRAIN_CYC+2
- mode_ack at N+DRAIN_CYC+SETTLE_CYC+2
REQ-025 In ACTIVE with irxen=010, rx_dp_rstb SHALL be 0.
REQ-026 force_dis=1 in any state SHALL set the target to 010 and enter DRAIN on the next cycle with the DRAIN counter restarted.
REQ-027 If force_dis aborts an in-progress request, mode_err SHALL pulse once and no mode_ack SHALL be issued for that request.
REQ-028 force_dis=1 in ACTIVE with irxen already 010 SHALL cause no state change and no pulse.
REQ-029 If force_dis and mode_req are both 1 in the same cycle, force_dis SHALL win and the request SHALL receive mode_err.
REQ-030 The cycle counter SHALL be 4 bits and SHALL never wrap; it reloads on every state entry.
REQ-031 mode_ack and mode_err SHALL never both be 1 in the same cycle.

Reset
REQ-032 While irstb=0 at a clock edge, the following SHALL apply:
- state = ACTIVE
- irxen = 010
- rx_dp_rstb = 0
- busy, mode_ack, mode_err = 0
- target = 010
- counter = 0
REQ-033 Reset asserted mid-sequence SHALL abandon the sequence without any ack or err pulse.
REQ-034 The first request SHALL be accepted in the first cycle with irstb=1.

Verification
REQ-035 After reset, request mode_new=001 at cycle N (defaults) -> rx_dp_rstb stays 0, irxen=001 at N+6, mode_ack=1 and rx_dp_rstb=1 at N+14, busy=1 during N+1..N+13.
REQ-036 In ACTIVE at 001, request 101 -> mode_err at N+1; irxen stays 001 and rx_dp_rstb stays 1.
REQ-037 Moving 001 to 011, second request 100 issued at N+3 -> mode_err at N+4, mode_ack at N+14, final irxen=011.
REQ-038 Moving 000 to 100, force_dis during SETTLE at cycle M -> mode_err at M+1, irxen=010 at M+DRAIN_CYC+2, no mode_ack, rx_dp_rstb=0 throughout.
REQ-039 Same-mode request 011 while at 011 -> mode_ack at N+1 and busy never asserts.
REQ-040 irstb=0 during DRAIN -> next cycle irxen=010, busy=0, no pulses; with DRAIN_CYC=1 and SETTLE_CYC=1 a request completes at N+4.
